// File: rtl/invaders_pkg.sv
// Shared types and default constants for the invaders formation mover.
package invaders_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MARCH,
    LANDED
  } state_t;

  typedef logic [10:0] coord_t;
  typedef logic [11:0] wide_t;
  typedef logic [7:0]  frame_t;

  localparam int unsigned DEF_INIT_X       = 32;
  localparam int unsigned DEF_INIT_Y       = 32;
  localparam int unsigned DEF_STEP_X       = 8;
  localparam int unsigned DEF_STEP_Y       = 16;
  localparam int unsigned DEF_FORM_W       = 256;
  localparam int unsigned DEF_FORM_H       = 128;
  localparam int unsigned DEF_RIGHT_LIMIT  = 640;
  localparam int unsigned DEF_BOTTOM_LIMIT = 448;
  localparam int unsigned DEF_PERIOD_INIT  = 16;
  localparam int unsigned DEF_PERIOD_MIN   = 2;

endpackage

// File: rtl/invaders_mover_frame_divider.sv
// Frame pacing: counts frames while marching and emits stepTick every `period` frames.
module frame_divider
  import invaders_pkg::*;
#(
  parameter int unsigned PERIOD_INIT = DEF_PERIOD_INIT,
  parameter int unsigned PERIOD_MIN  = DEF_PERIOD_MIN
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  input  logic active,
  input  logic startOfFrame,
  input  logic speedUp,
  output logic stepTick
);

  frame_t frame_cnt;
  frame_t period;
  logic   last_frame;

  // frame_cnt + 1 >= period, widened so period-1 never underflows
  always_comb begin
    last_frame = ({1'b0, frame_cnt} + 9'd1) >= {1'b0, period};
    stepTick   = active && startOfFrame && !restart && last_frame;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      period    <= frame_t'(PERIOD_INIT);
    end else if (restart) begin
      frame_cnt <= '0;
      period    <= frame_t'(PERIOD_INIT);
    end else begin
      if (active && startOfFrame)
        frame_cnt <= last_frame ? '0 : frame_cnt + 8'd1;
      // Step test above uses the pre-decrement period when both arrive together.
      if (speedUp)
        period <= (period > frame_t'(PERIOD_MIN)) ? period - 8'd1 : frame_t'(PERIOD_MIN);
    end
  end

endmodule

// File: rtl/invaders_mover.sv
// Space-invaders formation mover: marches the block left/right, descends at edges, lands at the bottom.
module invaders_mover
  import invaders_pkg::*;
#(
  parameter int unsigned INIT_X       = DEF_INIT_X,
  parameter int unsigned INIT_Y       = DEF_INIT_Y,
  parameter int unsigned STEP_X       = DEF_STEP_X,
  parameter int unsigned STEP_Y       = DEF_STEP_Y,
  parameter int unsigned FORM_W       = DEF_FORM_W,
  parameter int unsigned FORM_H       = DEF_FORM_H,
  parameter int unsigned RIGHT_LIMIT  = DEF_RIGHT_LIMIT,
  parameter int unsigned BOTTOM_LIMIT = DEF_BOTTOM_LIMIT,
  parameter int unsigned PERIOD_INIT  = DEF_PERIOD_INIT,
  parameter int unsigned PERIOD_MIN   = DEF_PERIOD_MIN
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        enable,
  input  logic        restart,
  input  logic        speedUp,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        stepPulse,
  output logic        landed
);

  state_t state, state_next;
  logic   dirRight;
  logic   active;
  logic   step_tick;
  logic   right_ok, left_ok, descend, lands;
  wide_t  y_down;
  coord_t x_next, y_next;

  assign active = (state == MARCH) && enable;

  frame_divider #(
    .PERIOD_INIT(PERIOD_INIT),
    .PERIOD_MIN (PERIOD_MIN)
  ) u_divider (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .active      (active),
    .startOfFrame(startOfFrame),
    .speedUp     (speedUp),
    .stepTick    (step_tick)
  );

  // Limit tests at 12 bits so no sum or difference wraps.
  always_comb begin
    right_ok = ({1'b0, topLeftX} + wide_t'(STEP_X) + wide_t'(FORM_W)) <= wide_t'(RIGHT_LIMIT);
    left_ok  = {1'b0, topLeftX} >= wide_t'(STEP_X);
    descend  = dirRight ? !right_ok : !left_ok;
    y_down   = {1'b0, topLeftY} + wide_t'(STEP_Y);
    lands    = (y_down + wide_t'(FORM_H)) >= wide_t'(BOTTOM_LIMIT);
    x_next   = dirRight ? topLeftX + coord_t'(STEP_X) : topLeftX - coord_t'(STEP_X);
    y_next   = topLeftY + coord_t'(STEP_Y);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (restart)
      state_next = IDLE;
    else begin
      case (state)
        IDLE:    if (enable) state_next = MARCH;
        MARCH: begin
          if (!enable)
            state_next = IDLE;
          else if (step_tick && descend && lands)
            state_next = LANDED;
        end
        LANDED:  state_next = LANDED;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    landed = (state == LANDED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      topLeftX  <= coord_t'(INIT_X);
      topLeftY  <= coord_t'(INIT_Y);
      dirRight  <= 1'b1;
      stepPulse <= 1'b0;
    end else if (restart) begin
      topLeftX  <= coord_t'(INIT_X);
      topLeftY  <= coord_t'(INIT_Y);
      dirRight  <= 1'b1;
      stepPulse <= 1'b0;
    end else begin
      stepPulse <= step_tick;
      if (step_tick) begin
        if (descend) begin
          topLeftY <= y_next;
          dirRight <= !dirRight;
        end else begin
          topLeftX <= x_next;
        end
      end
    end
  end

endmodule
